parser_rule_loader: RTL

- Configuration initiator for the pipelined packet parser rule interface; it drives the rule-side ports (wren/rden/addr/wdata) that the parser top and its layers consume.
- Accepts a 32-bit command word stream from the host or control path with a valid/ready handshake, and decodes it into single-cycle rule write/read strobes with address auto-increment.
- Collects read data or times out, and returns response words on a valid/ready stream.

---
 rtl/parser_cfg_pkg.sv | 23 ++
 rtl/parser_rule_loader_if.sv | 26 ++
 rtl/parser_cfg_timer.sv | 22 ++
 rtl/parser_rule_loader.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/parser_cfg_pkg.sv
// Shared types and constants for the parser rule loader: opcodes, FSM states,
// response tag and the layer-select field of a rule address.
package parser_cfg_pkg;
    typedef enum logic [1:0] {
        OP_ILL0  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_ILL3  = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_WDONE, S_RD_ISSUE, S_RD_WAIT, S_RESP
    } state_e;

    localparam logic [7:0] WDONE_TAG = 8'hC1;
    localparam int         LAYER_MSB = 31;
    localparam int         LAYER_LSB = 24;

    // Low 24 bits wrap; the layer byte is carried through untouched.
    function automatic logic [31:0] next_addr(input logic [31:0] a);
        return {a[LAYER_MSB:LAYER_LSB], a[LAYER_LSB-1:0] + 24'd1};
    endfunction
endpackage

// File: rtl/parser_rule_loader_if.sv
// Command, response and rule-side bus bundle of the parser rule loader.
interface parser_rule_loader_if;
    logic        i_cmd_valid;
    logic [31:0] i_cmd_data;
    logic        o_cmd_ready;
    logic        o_resp_valid;
    logic [31:0] o_resp_data;
    logic        i_resp_ready;
    logic        o_rule_wren;
    logic        o_rule_rden;
    logic [31:0] o_rule_addr;
    logic [31:0] o_rule_wdata;
    logic        i_rule_rdata_valid;
    logic [31:0] i_rule_rdata;

    modport slave (
        input  i_cmd_valid, i_cmd_data, i_resp_ready, i_rule_rdata_valid, i_rule_rdata,
        output o_cmd_ready, o_resp_valid, o_resp_data, o_rule_wren, o_rule_rden,
               o_rule_addr, o_rule_wdata
    );
    modport master (
        output i_cmd_valid, i_cmd_data, i_resp_ready, i_rule_rdata_valid, i_rule_rdata,
        input  o_cmd_ready, o_resp_valid, o_resp_data, o_rule_wren, o_rule_rden,
               o_rule_addr, o_rule_wdata
    );
endinterface

// File: rtl/parser_cfg_timer.sv
// Loadable down-counter; o_expired is high on the TIMEOUT_CYC-th enabled cycle after load.
module parser_cfg_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = $clog2(TIMEOUT_CYC);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                  r_cnt <= '0;
        else if (i_load)               r_cnt <= W'(TIMEOUT_CYC - 1);
        else if (i_en && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
    end

    assign o_expired = (r_cnt == '0);
endmodule

// File: rtl/parser_rule_loader.sv
// Decodes a host command word stream into rule write/read strobes with address
// auto-increment, and returns write-done / read-data responses.
module parser_rule_loader
    import parser_cfg_pkg::*;
#(
    parameter int          TIMEOUT_CYC     = 64,
    parameter logic [31:0] TIMEOUT_PATTERN = 32'hDEAD_BEEF,
    parameter int          CNT_WIDTH       = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    parser_rule_loader_if.slave  bus,
    input  logic                 i_err_clr,
    output logic                 o_busy,
    output logic                 o_err_timeout,
    output logic                 o_err_cmd,
    output logic [CNT_WIDTH-1:0] o_wr_cnt,
    output logic [CNT_WIDTH-1:0] o_rd_cnt
);
    state_e               r_state;
    opcode_e              r_op;
    logic [15:0]          r_len, r_remain;
    logic [31:0]          r_addr, r_rule_addr, r_rule_wdata, r_resp_data;
    logic                 r_cmd_ready, r_resp_valid, r_wren, r_rden;
    logic                 r_err_timeout, r_err_cmd;
    logic [CNT_WIDTH-1:0] r_wr_cnt, r_rd_cnt;

    logic    w_acc, w_tmr_exp;
    opcode_e w_op;

    assign w_acc = bus.i_cmd_valid & r_cmd_ready;
    assign w_op  = opcode_e'(bus.i_cmd_data[31:30]);

    parser_cfg_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (r_state == S_RD_ISSUE),
        .i_en      (r_state == S_RD_WAIT),
        .o_expired (w_tmr_exp)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_op          <= OP_ILL0;
            r_len         <= '0;
            r_remain      <= '0;
            r_addr        <= '0;
            r_rule_addr   <= '0;
            r_rule_wdata  <= '0;
            r_resp_data   <= '0;
            r_cmd_ready   <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_wren        <= 1'b0;
            r_rden        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_cmd     <= 1'b0;
            r_wr_cnt      <= '0;
            r_rd_cnt      <= '0;
        end else begin
            r_wren <= 1'b0;
            r_rden <= 1'b0;
            // Clear first so a set later in this block takes priority.
            if (i_err_clr) begin
                r_err_timeout <= 1'b0;
                r_err_cmd     <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_acc) begin
                        if (w_op == OP_WRITE || w_op == OP_READ) begin
                            r_op    <= w_op;
                            r_len   <= bus.i_cmd_data[15:0];
                            r_state <= S_ADDR;
                        end else begin
                            r_err_cmd <= 1'b1;
                        end
                    end
                end
                S_ADDR: if (w_acc) begin
                    r_addr   <= bus.i_cmd_data;
                    r_remain <= r_len;
                    if (r_len == 16'd0) begin
                        r_state <= S_IDLE;
                    end else if (r_op == OP_WRITE) begin
                        r_state <= S_WDATA;
                    end else begin
                        r_state     <= S_RD_ISSUE;
                        r_cmd_ready <= 1'b0;
                    end
                end
                S_WDATA: if (w_acc) begin
                    r_wren       <= 1'b1;
                    r_wr_cnt     <= r_wr_cnt + CNT_WIDTH'(1);
                    r_rule_addr  <= r_addr;
                    r_rule_wdata <= bus.i_cmd_data;
                    r_addr       <= next_addr(r_addr);
                    r_remain     <= r_remain - 16'd1;
                    if (r_remain == 16'd1) begin
                        r_state      <= S_WDONE;
                        r_cmd_ready  <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= {WDONE_TAG, 8'h00, r_len};
                    end
                end
                S_WDONE: if (bus.i_resp_ready) begin
                    r_resp_valid <= 1'b0;
                    r_cmd_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
                S_RD_ISSUE: begin
                    r_rden      <= 1'b1;
                    r_rule_addr <= r_addr;
                    r_rd_cnt    <= r_rd_cnt + CNT_WIDTH'(1);
                    r_state     <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (bus.i_rule_rdata_valid) begin
                        r_resp_data  <= bus.i_rule_rdata;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (w_tmr_exp) begin
                        r_resp_data   <= TIMEOUT_PATTERN;
                        r_resp_valid  <= 1'b1;
                        r_err_timeout <= 1'b1;
                        r_state       <= S_RESP;
                    end
                end
                S_RESP: if (bus.i_resp_ready) begin
                    r_resp_valid <= 1'b0;
                    r_addr       <= next_addr(r_addr);
                    r_remain     <= r_remain - 16'd1;
                    if (r_remain == 16'd1) begin
                        r_state     <= S_IDLE;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_state <= S_RD_ISSUE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_cmd_ready  = r_cmd_ready;
    assign bus.o_resp_valid = r_resp_valid;
    assign bus.o_resp_data  = r_resp_data;
    assign bus.o_rule_wren  = r_wren;
    assign bus.o_rule_rden  = r_rden;
    assign bus.o_rule_addr  = r_rule_addr;
    assign bus.o_rule_wdata = r_rule_wdata;
    assign o_busy           = (r_state != S_IDLE);
    assign o_err_timeout    = r_err_timeout;
    assign o_err_cmd        = r_err_cmd;
    assign o_wr_cnt         = r_wr_cnt;
    assign o_rd_cnt         = r_rd_cnt;
endmodule
